// File: rtl/bench_app_responder.sv
// PCIe round-trip latency benchmark responder: emits one F2C chunk when armed and times
// how long the host takes to answer with a C2F chunk or a burst of register writes.
module bench_app_responder #(
  parameter logic [6:0] REG_TIMER      = 7'd32,
  parameter logic [6:0] REG_SINGLE     = 7'd33,
  parameter int         F2C_CHUNK_QW   = 512,
  parameter int         C2F_CHUNK_QW   = 128,
  parameter int         REG_RESP_COUNT = 256
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  input  logic [6:0]  cpuChan_in,
  input  logic [31:0] cpuWrData_in,
  input  logic        cpuWrValid_in,
  output logic        cpuWrReady_out,
  output logic [31:0] cpuRdData_out,
  output logic        cpuRdValid_out,
  input  logic        cpuRdReady_in,
  output logic [63:0] f2cData_out,
  output logic        f2cValid_out,
  input  logic        f2cReady_in,
  input  logic        f2cReset_in,
  input  logic [63:0] c2fData_in,
  input  logic        c2fValid_in,
  output logic        c2fReady_out
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  typedef struct packed {
    logic        vld;
    logic [6:0]  chan;
    logic [31:0] data;
  } reg_wr_t;

  localparam logic [31:0] LAST_QW   = 32'(F2C_CHUNK_QW - 1);
  localparam logic [15:0] C2F_TGT   = 16'(C2F_CHUNK_QW);
  localparam logic [15:0] MULTI_TGT = 16'(REG_RESP_COUNT);

  state_t      state, state_nxt;
  reg_wr_t     wr;
  logic [31:0] timer;
  logic [31:0] qw_idx;
  logic [15:0] c2f_cnt, c2f_cnt_nxt;
  logic [15:0] reg_cnt, reg_cnt_nxt;
  logic [15:0] reg_tgt;
  logic        single;
  logic        rdy;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        wr_timer, running, arm, f2c_fire, last_beat, complete;
  logic        in_unused;

  // Payload and the upper write-data bits carry no meaning here.
  assign in_unused = ^{c2fData_in, cpuWrData_in[31:1]};

  assign wr       = '{vld: cpuWrValid_in, chan: cpuChan_in, data: cpuWrData_in};
  assign wr_timer = wr.vld && (wr.chan == REG_TIMER);
  assign running  = (state == SEND) || (state == WAIT);
  assign arm      = ((state == IDLE) || (state == DONE)) && wr_timer;
  assign f2c_fire = (state == SEND) && f2cReady_in;
  assign last_beat = f2c_fire && (qw_idx == LAST_QW);
  assign reg_tgt  = single ? 16'd1 : MULTI_TGT;

  // Counters saturate, so >= also catches a response that finished while still sending.
  always_comb begin
    c2f_cnt_nxt = c2f_cnt;
    reg_cnt_nxt = reg_cnt;
    if (running && c2fValid_in && (c2f_cnt != 16'hFFFF)) c2f_cnt_nxt = c2f_cnt + 16'd1;
    if (running && wr_timer && (reg_cnt != 16'hFFFF))    reg_cnt_nxt = reg_cnt + 16'd1;
    complete = (c2f_cnt_nxt >= C2F_TGT) || (reg_cnt_nxt >= reg_tgt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (wr_timer)  state_nxt = SEND;
      SEND:       if (last_beat) state_nxt = complete ? DONE : WAIT;
      WAIT:       if (complete)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (f2cReset_in) state_nxt = IDLE;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state   <= IDLE;
      timer   <= '0;
      qw_idx  <= '0;
      c2f_cnt <= '0;
      reg_cnt <= '0;
      single  <= 1'b0;
      rdy     <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rdy   <= 1'b1;
      state <= state_nxt;
      if (arm) begin
        timer   <= '0;
        qw_idx  <= '0;
        c2f_cnt <= '0;
        reg_cnt <= '0;
      end else begin
        if (running && (timer != 32'hFFFF_FFFF)) timer <= timer + 32'd1;
        if (f2c_fire) qw_idx <= qw_idx + 32'd1;
        c2f_cnt <= c2f_cnt_nxt;
        reg_cnt <= reg_cnt_nxt;
      end
      if (wr.vld && (wr.chan == REG_SINGLE)) single <= wr.data[0];
      rd_vld <= cpuRdReady_in;
      if (cpuRdReady_in) begin
        if (cpuChan_in == REG_TIMER)       rd_data <= timer;
        else if (cpuChan_in == REG_SINGLE) rd_data <= {31'b0, single};
        else                               rd_data <= '0;
      end
    end
  end

  assign cpuWrReady_out = rdy;
  assign c2fReady_out   = rdy;
  assign cpuRdValid_out = rd_vld;
  assign cpuRdData_out  = rd_data;
  assign f2cValid_out   = (state == SEND);
  assign f2cData_out    = (state == SEND) ? {~qw_idx, qw_idx} : 64'd0;

endmodule

// File: tb/tb_bench_app_responder.sv
// Bench for bench_app_responder: F2C scoreboard, register vector table, timed run scenarios.
`timescale 1ns/1ps
module tb_bench_app_responder;

  localparam logic [6:0] REG_TIMER  = 7'd32;
  localparam logic [6:0] REG_SINGLE = 7'd33;

  logic        clk_in = 1'b0;
  logic        rstn_in = 1'b0;
  logic [6:0]  cpuChan_in = '0;
  logic [31:0] cpuWrData_in = '0;
  logic        cpuWrValid_in = 1'b0;
  logic        cpuWrReady_out;
  logic [31:0] cpuRdData_out;
  logic        cpuRdValid_out;
  logic        cpuRdReady_in = 1'b0;
  logic [63:0] f2cData_out;
  logic        f2cValid_out;
  logic        f2cReady_in = 1'b0;
  logic        f2cReset_in = 1'b0;
  logic [63:0] c2fData_in = '0;
  logic        c2fValid_in = 1'b0;
  logic        c2fReady_out;

  bench_app_responder dut (
    .clk_in(clk_in), .rstn_in(rstn_in),
    .cpuChan_in(cpuChan_in), .cpuWrData_in(cpuWrData_in), .cpuWrValid_in(cpuWrValid_in),
    .cpuWrReady_out(cpuWrReady_out), .cpuRdData_out(cpuRdData_out), .cpuRdValid_out(cpuRdValid_out),
    .cpuRdReady_in(cpuRdReady_in), .f2cData_out(f2cData_out), .f2cValid_out(f2cValid_out),
    .f2cReady_in(f2cReady_in), .f2cReset_in(f2cReset_in), .c2fData_in(c2fData_in),
    .c2fValid_in(c2fValid_in), .c2fReady_out(c2fReady_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int          beat_no = 0;
  logic        stalled = 1'b0;
  logic [63:0] stall_data = '0;

  typedef struct {
    logic        do_wr;
    logic [6:0]  wr_chan;
    logic [31:0] wdata;
    logic [6:0]  rd_chan;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr_reg(input logic [6:0] ch, input logic [31:0] d);
    cpuChan_in = ch; cpuWrData_in = d; cpuWrValid_in = 1'b1;
    tick();
    cpuWrValid_in = 1'b0;
  endtask

  task automatic rd_reg(input logic [6:0] ch, output logic [31:0] d);
    cpuChan_in = ch; cpuRdReady_in = 1'b1;
    tick();
    cpuRdReady_in = 1'b0;
    check("rd_valid", cpuRdValid_out, 1'b1);
    d = cpuRdData_out;
  endtask

  // Queue the whole expected chunk, then issue the arming write.
  task automatic arm();
    exp_q.delete();
    beat_no = 0;
    for (int i = 0; i < 512; i++) exp_q.push_back({~32'(i), 32'(i)});
    wr_reg(REG_TIMER, 32'h0);
  endtask

  // F2C scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (rstn_in && stalled) begin
      check("f2c_hold_valid", f2cValid_out, 1'b1);
      check("f2c_hold_data", f2cData_out, stall_data);
    end
    if (rstn_in && !f2cReset_in && f2cValid_out && f2cReady_in) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL f2c_extra_beat: got %h expected no beat", f2cData_out);
      end else begin
        check("f2c_beat", f2cData_out, exp_q.pop_front());
        if (beat_no == 5) check("f2c_beat5", f2cData_out, 64'hFFFFFFFA_00000005);
        beat_no++;
      end
    end
    stalled    = rstn_in && !f2cReset_in && f2cValid_out && !f2cReady_in;
    stall_data = f2cData_out;
  end

  initial begin
    logic [31:0] a, b;

    vt[0] = '{1'b1, REG_SINGLE, 32'h0000_0001, REG_SINGLE, 32'h1};
    vt[1] = '{1'b1, REG_SINGLE, 32'hFFFF_FFFE, REG_SINGLE, 32'h0};
    vt[2] = '{1'b1, REG_SINGLE, 32'hFFFF_FFFF, REG_SINGLE, 32'h1};
    vt[3] = '{1'b1, 7'd34,      32'hFFFF_FFFF, 7'd34,      32'h0};
    vt[4] = '{1'b0, 7'd0,       32'h0,         REG_SINGLE, 32'h1};
    vt[5] = '{1'b0, 7'd0,       32'h0,         7'd0,       32'h0};
    vt[6] = '{1'b0, 7'd0,       32'h0,         7'd127,     32'h0};
    vt[7] = '{1'b1, REG_SINGLE, 32'h0000_0002, REG_TIMER,  32'h0};

    // 1: reset state and first read
    #2;
    check("rst_wr_ready", cpuWrReady_out, 1'b0);
    check("rst_c2f_ready", c2fReady_out, 1'b0);
    check("rst_f2c_valid", f2cValid_out, 1'b0);
    check("rst_rd_valid", cpuRdValid_out, 1'b0);
    tick(); tick();
    rstn_in = 1'b1;
    check("rel_wr_ready_lo", cpuWrReady_out, 1'b0);
    tick();
    check("rel_wr_ready", cpuWrReady_out, 1'b1);
    check("rel_c2f_ready", c2fReady_out, 1'b1);
    rd_reg(REG_TIMER, a);
    check("t1_timer", a, 32'd0);
    tick();
    check("t1_rd_valid_pulse", cpuRdValid_out, 1'b0);
    check("t1_f2c_valid", f2cValid_out, 1'b0);

    // Register table (ends with single cleared)
    foreach (vt[i]) begin
      if (vt[i].do_wr) wr_reg(vt[i].wr_chan, vt[i].wdata);
      rd_reg(vt[i].rd_chan, a);
      check($sformatf("vec%0d_rd", i), a, vt[i].exp);
    end

    // 2: full chunk, gap, then C2F chunk completes the run
    f2cReady_in = 1'b1;
    arm();
    repeat (512) tick();
    check("t2_valid_after_chunk", f2cValid_out, 1'b0);
    check("t2_beats", beat_no, 512);
    repeat (10) tick();
    c2fValid_in = 1'b1;
    repeat (128) tick();
    c2fValid_in = 1'b0;
    repeat (3) tick();
    rd_reg(REG_TIMER, a);
    check("t2_timer", a, 32'd650);
    rd_reg(REG_TIMER, b);
    check("t2_timer_frozen", b, 32'd650);

    // 3: multi-reg completion after 256 TIMER writes in WAIT
    arm();
    repeat (512) tick();
    cpuChan_in = REG_TIMER; cpuWrValid_in = 1'b1;
    repeat (255) tick();
    cpuWrValid_in = 1'b0;
    rd_reg(REG_TIMER, a);
    check("t3_timer_255", a, 32'd767);
    rd_reg(REG_TIMER, b);
    check("t3_timer_running", b, 32'd768);
    wr_reg(REG_TIMER, 32'h0);
    rd_reg(REG_TIMER, a);
    check("t3_timer_256", a, 32'd770);
    rd_reg(REG_TIMER, b);
    check("t3_timer_frozen", b, 32'd770);

    // 4: single-reg mode, response arrives during SEND
    wr_reg(REG_SINGLE, 32'h1);
    arm();
    for (int i = 0; i < 512; i++) begin
      cpuChan_in = REG_TIMER; cpuWrValid_in = (i == 0);
      tick();
    end
    cpuWrValid_in = 1'b0;
    check("t4_valid_low", f2cValid_out, 1'b0);
    rd_reg(REG_TIMER, a);
    check("t4_timer", a, 32'd512);
    rd_reg(REG_TIMER, b);
    check("t4_timer_frozen", b, 32'd512);
    wr_reg(REG_SINGLE, 32'h0);

    // 5: random backpressure
    arm();
    for (int c = 0; c < 4000 && exp_q.size() != 0; c++) begin
      f2cReady_in = 1'($urandom_range(0, 1));
      tick();
    end
    check("t5_drained", exp_q.size(), 0);
    check("t5_beats", beat_no, 512);
    f2cReady_in = 1'b1;
    tick();
    check("t5_valid_low", f2cValid_out, 1'b0);
    f2cReset_in = 1'b1;
    tick();
    f2cReset_in = 1'b0;

    // 6a: f2cReset_in mid-SEND
    arm();
    repeat (100) tick();
    f2cReady_in = 1'b0;
    f2cReset_in = 1'b1;
    tick();
    f2cReset_in = 1'b0;
    check("t6_valid_drop", f2cValid_out, 1'b0);
    exp_q.delete();
    tick();
    check("t6_stays_idle", f2cValid_out, 1'b0);
    rd_reg(REG_TIMER, a);
    rd_reg(REG_TIMER, b);
    check("t6_timer_kept", (a >= 32'd100) && (a <= 32'd101), 1'b1);
    check("t6_timer_idle_hold", b, a);

    // 6b: rstn_in mid-WAIT
    f2cReady_in = 1'b1;
    arm();
    repeat (517) tick();
    check("t6_in_wait", f2cValid_out, 1'b0);
    #2 rstn_in = 1'b0;
    #1;
    check("t6_rst_wr_ready", cpuWrReady_out, 1'b0);
    check("t6_rst_c2f_ready", c2fReady_out, 1'b0);
    @(posedge clk_in); #1;
    rstn_in = 1'b1;
    tick();
    check("t6_ready_back", cpuWrReady_out, 1'b1);
    rd_reg(REG_TIMER, a);
    check("t6_timer_reset", a, 32'd0);
    check("t6_f2c_idle", f2cValid_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
